gpio_dbg_bridge: RTL

GPIO_DBG_BRIDGE -- requirements
Module: gpio_dbg_bridge

---
 rtl/gpio_dbg_bridge.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gpio_dbg_bridge.sv
// gpio_dbg_bridge: GPIO-word command bridge driving N_CHANNELS debug targets with write/read handshakes.
// Define GPIO_DBG_BRIDGE_TIMEOUT_EN to abort reads that see no rvalid within TIMEOUT cycles.
module gpio_dbg_bridge #(
    parameter int NB_BITS    = 32,
    parameter int NB_CH      = 4,
    parameter int N_CHANNELS = 4,
    parameter int NB_SYNC    = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NB_BITS-1:0]            i_gpio_out,
    output logic [NB_BITS-1:0]            o_gpio_data,
    output logic [NB_BITS-1:0]            o_gpio_status,
    output logic [NB_BITS-NB_CH-4:0]      o_ch_data,
    output logic [N_CHANNELS-1:0]         o_ch_wr,
    output logic [N_CHANNELS-1:0]         o_ch_rd,
    input  logic [N_CHANNELS*NB_BITS-1:0] i_ch_rdata,
    input  logic [N_CHANNELS-1:0]         i_ch_rvalid,
    output logic                          o_continue
);
    localparam int NB_DATA = NB_BITS-3-NB_CH;
    localparam logic [NB_CH:0] N_CH_W = (NB_CH+1)'(N_CHANNELS);

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [NB_SYNC-1:0]   stb_sync_q, stb_sync_d, cont_sync_q, cont_sync_d, fill_q, fill_d;
    logic                 stb_prev_q, stb_prev_d, cont_prev_q, cont_prev_d, arm_q, arm_d;
    logic [NB_CH-1:0]     idx_q, idx_d;
    logic [NB_DATA-1:0]   payload_q, payload_d;
    logic [NB_BITS-1:0]   data_q, data_d;
    logic                 busy_q, busy_d, err_q, err_d, ack_q, ack_d;
    logic                 stb_s, cont_s, stb_edge, in_rnw, bad_idx, hit, tmo;
    logic [NB_CH-1:0]     in_idx;
    logic [NB_DATA-1:0]   in_payload;
    logic [N_CHANNELS-1:0] sel;
    logic [NB_BITS-1:0]   rdata_sel;

    assign in_rnw     = i_gpio_out[NB_BITS-3];
    assign in_idx     = i_gpio_out[NB_BITS-4 -: NB_CH];
    assign in_payload = i_gpio_out[NB_DATA-1:0];
    assign bad_idx    = {1'b0, in_idx} >= N_CH_W;
    assign stb_s      = stb_sync_q[NB_SYNC-1];
    assign cont_s     = cont_sync_q[NB_SYNC-1];

    // arm_q only sets once a real (post-reset) low strobe has been seen, so a strobe held across reset is not a command
    assign stb_edge   = stb_s & ~stb_prev_q & arm_q;
    assign o_continue = cont_s & ~cont_prev_q;

    always_comb begin
        stb_sync_d  = {stb_sync_q[NB_SYNC-2:0], i_gpio_out[NB_BITS-2]};
        cont_sync_d = {cont_sync_q[NB_SYNC-2:0], i_gpio_out[NB_BITS-1]};
        fill_d      = {fill_q[NB_SYNC-2:0], 1'b1};
        arm_d       = arm_q | (fill_q[NB_SYNC-1] & ~stb_s);
        stb_prev_d  = stb_s;
        cont_prev_d = cont_s;
    end

    always_comb begin
        sel       = '0;
        rdata_sel = '0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            sel[k]    = idx_q == NB_CH'(k);
            rdata_sel = rdata_sel | ({NB_BITS{sel[k]}} & i_ch_rdata[k*NB_BITS +: NB_BITS]);
        end
        hit = |(sel & i_ch_rvalid);
    end

`ifdef GPIO_DBG_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT+1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = state_q == READ_WAIT ? cnt_q + 1'b1 : '0;
        tmo   = state_q == READ_WAIT && cnt_q == CW'(TIMEOUT-1);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif

    // ack toggles and busy clears on the transition into DONE so ack lands one cycle after the wr pulse
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        payload_d = payload_q;
        data_d    = data_q;
        busy_d    = busy_q;
        err_d     = err_q;
        ack_d     = ack_q;
        case (state_q)
            IDLE: if (stb_edge) begin
                idx_d     = in_idx;
                payload_d = in_payload;
                err_d     = bad_idx;
                busy_d    = !bad_idx;
                ack_d     = bad_idx ? ~ack_q : ack_q;
                state_d   = bad_idx ? DONE : in_rnw ? READ_WAIT : WRITE;
            end
            WRITE: begin
                busy_d  = 1'b0;
                ack_d   = ~ack_q;
                state_d = DONE;
            end
            READ_WAIT: if (hit || tmo) begin
                data_d  = hit ? rdata_sel : data_q;
                err_d   = !hit;
                busy_d  = 1'b0;
                ack_d   = ~ack_q;
                state_d = DONE;
            end
            default: state_d = stb_s ? DONE : IDLE;
        endcase
    end

    always_comb begin
        o_ch_wr       = state_q == WRITE ? sel : '0;
        o_ch_rd       = state_q == READ_WAIT ? sel : '0;
        o_ch_data     = payload_q;
        o_gpio_data   = data_q;
        o_gpio_status = '0;
        o_gpio_status[0] = busy_q;
        o_gpio_status[1] = err_q;
        o_gpio_status[2] = ack_q;
        o_gpio_status[NB_CH+7:8] = idx_q;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            stb_sync_q  <= '0;
            cont_sync_q <= '0;
            fill_q      <= '0;
            arm_q       <= 1'b0;
            stb_prev_q  <= 1'b0;
            cont_prev_q <= 1'b0;
            idx_q       <= '0;
            payload_q   <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stb_sync_q  <= stb_sync_d;
            cont_sync_q <= cont_sync_d;
            fill_q      <= fill_d;
            arm_q       <= arm_d;
            stb_prev_q  <= stb_prev_d;
            cont_prev_q <= cont_prev_d;
            idx_q       <= idx_d;
            payload_q   <= payload_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            ack_q       <= ack_d;
        end
    end
endmodule
